// File: rtl/alu_vector_bist.sv
// rtl/alu_vector_bist.sv - vector-memory sequencer that drives an alu and checks its result and flags
module alu_vector_bist #(
  parameter int WIDTH       = 4,
  parameter int NUM_VECTORS = 16,
  parameter int AW          = $clog2(NUM_VECTORS),
  parameter int VW          = 3*WIDTH+6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vec_we,
  input  logic [AW-1:0]    vec_addr,
  input  logic [VW-1:0]    vec_wdata,
  input  logic [AW:0]      vec_count,
  input  logic             start,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [1:0]       alu_control,
  input  logic [WIDTH-1:0] result,
  input  logic [3:0]       alu_flags,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [AW:0]      err_count,
  output logic [AW-1:0]    first_fail_idx
);

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_CHECK, S_DONE} state_t;

  localparam logic [AW:0] NV = (AW+1)'(NUM_VECTORS);

  state_t           state;
  state_t           state_next;
  logic [VW-1:0]    mem [NUM_VECTORS];
  logic [VW-1:0]    vec_word;
  logic [AW-1:0]    idx;
  logic [AW:0]      count;
  logic [AW:0]      count_req;
  logic [WIDTH-1:0] exp_result;
  logic [3:0]       exp_flags;
  logic             mismatch;
  logic             last_vec;

  // Word layout, MSB first: a, b, alu_control, exp_result, exp_flags
  assign vec_word  = mem[idx];
  assign count_req = (vec_count > NV) ? NV : vec_count;
  assign last_vec  = ({1'b0, idx} == (count - 1'b1));
  assign mismatch  = (result != exp_result) || (alu_flags != exp_flags);
  assign busy      = (state == S_APPLY) || (state == S_CHECK);
  assign done      = (state == S_DONE);

  // Vector memory: writes only while not running, out-of-range addresses dropped
  always_ff @(posedge clk) begin
    if (vec_we && !busy && ({1'b0, vec_addr} < NV))
      mem[vec_addr] <= vec_wdata;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state: two cycles per vector, an empty run goes straight to DONE
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_next = (count_req == '0) ? S_DONE : S_APPLY;
      S_APPLY:        state_next = S_CHECK;
      S_CHECK:        state_next = last_vec ? S_DONE : S_APPLY;
      default:        state_next = S_IDLE;
    endcase
  end

  // Datapath: latch run length, present vectors, accumulate mismatches
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a              <= '0;
      b              <= '0;
      alu_control    <= '0;
      exp_result     <= '0;
      exp_flags      <= '0;
      idx            <= '0;
      count          <= '0;
      err_count      <= '0;
      first_fail_idx <= '0;
      pass           <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            count          <= count_req;
            idx            <= '0;
            err_count      <= '0;
            first_fail_idx <= '0;
            pass           <= (count_req == '0);
          end
        end
        S_APPLY: begin
          a           <= vec_word[3*WIDTH+5 -: WIDTH];
          b           <= vec_word[2*WIDTH+5 -: WIDTH];
          alu_control <= vec_word[WIDTH+5 -: 2];
          exp_result  <= vec_word[WIDTH+3 -: WIDTH];
          exp_flags   <= vec_word[3:0];
        end
        S_CHECK: begin
          if (mismatch) begin
            if (err_count != NV) err_count <= err_count + 1'b1;
            if (err_count == '0) first_fail_idx <= idx;
          end
          if (last_vec) pass <= !mismatch && (err_count == '0);
          else          idx  <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_vector_bist.sv
// tb/tb_alu_vector_bist.sv - randomized self-checking bench for alu_vector_bist with a behavioural alu
module tb_alu_vector_bist;
  localparam int WIDTH = 4;
  localparam int NV    = 16;
  localparam int AW    = 4;
  localparam int VW    = 3*WIDTH+6;

  logic             clk = 1'b0;
  logic             reset;
  logic             vec_we;
  logic [AW-1:0]    vec_addr;
  logic [VW-1:0]    vec_wdata;
  logic [AW:0]      vec_count;
  logic             start;
  logic [WIDTH-1:0] a, b, result;
  logic [1:0]       alu_control;
  logic [3:0]       alu_flags;
  logic             busy, done, pass;
  logic [AW:0]      err_count;
  logic [AW-1:0]    first_fail_idx;

  int errors = 0;
  int checks = 0;
  logic [VW-1:0] model_mem [NV];

  always #5 clk = ~clk;

  // Reference alu: add/sub/and/or with flags {N, Z, C, V}
  function automatic logic [7:0] alu_ref(input logic [3:0] x, input logic [3:0] y, input logic [1:0] op);
    int s;
    logic [3:0] r;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      2'b00: begin s = int'(x) + int'(y); r = s[3:0]; c = (s > 15);
                   v = (x[3] == y[3]) && (r[3] != x[3]); end
      2'b01: begin s = int'(x) - int'(y); r = s[3:0]; c = (x < y);
                   v = (x[3] != y[3]) && (r[3] != x[3]); end
      2'b10: r = x & y;
      default: r = x | y;
    endcase
    return {r, r[3], (r == 4'd0), c, v};
  endfunction

  logic [7:0] alu_out;
  assign alu_out   = alu_ref(a, b, alu_control);
  assign result    = alu_out[7:4];
  assign alu_flags = alu_out[3:0];

  alu_vector_bist #(.WIDTH(WIDTH), .NUM_VECTORS(NV)) dut (
    .clk(clk), .reset(reset), .vec_we(vec_we), .vec_addr(vec_addr), .vec_wdata(vec_wdata),
    .vec_count(vec_count), .start(start), .a(a), .b(b), .alu_control(alu_control),
    .result(result), .alu_flags(alu_flags), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail_idx(first_fail_idx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".a"}, 32'(a), 0);
    chk({tag, ".b"}, 32'(b), 0);
    chk({tag, ".ctrl"}, 32'(alu_control), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".pass"}, 32'(pass), 0);
    chk({tag, ".err"}, 32'(err_count), 0);
    chk({tag, ".ffi"}, 32'(first_fail_idx), 0);
  endtask

  // mode 0: all correct, 1: exp_result of 5 and 9 wrong, 2: all flags wrong, 3: random corruption
  task automatic load_set(input int mode);
    logic [3:0] va, vb, cr, cf;
    logic [1:0] op;
    logic [7:0] ref_o;
    for (int i = 0; i < NV; i++) begin
      va = 4'($urandom); vb = 4'($urandom); op = 2'($urandom);
      ref_o = alu_ref(va, vb, op);
      cr = (mode == 1 && (i == 5 || i == 9)) ? 4'h1 : 4'h0;
      cf = (mode == 2) ? 4'hF : 4'h0;
      if (mode == 3 && $urandom_range(0, 3) == 0) cr = 4'($urandom_range(1, 15));
      model_mem[i] = {va, vb, op, ref_o[7:4] ^ cr, ref_o[3:0] ^ cf};
      vec_we = 1'b1; vec_addr = 4'(i); vec_wdata = model_mem[i];
      @(negedge clk);
      vec_we = 1'b0;
    end
  endtask

  task automatic predict(input int cnt, output int e, output int f);
    logic [VW-1:0] w;
    e = 0;
    f = 0;
    for (int i = 0; i < ((cnt > NV) ? NV : cnt); i++) begin
      w = model_mem[i];
      if (alu_ref(w[17:14], w[13:10], w[9:8]) != w[7:0]) begin
        if (e == 0) f = i;
        if (e < NV) e++;
      end
    end
  endtask

  // Runs cnt vectors; at cycle inject_at re-pulses start, writes memory and changes vec_count
  task automatic do_run(input string tag, input int cnt, input int inject_at);
    int exp_err, exp_ffi, eff, cycles;
    logic [VW-1:0] last;
    predict(cnt, exp_err, exp_ffi);
    eff = (cnt > NV) ? NV : cnt;
    vec_count = 5'(cnt);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    while (!done && cycles < 100) begin
      if (cycles == inject_at) begin
        start = 1'b1; vec_we = 1'b1; vec_addr = 4'd3; vec_wdata = ~model_mem[3]; vec_count = 5'd1;
      end
      @(negedge clk);
      start = 1'b0; vec_we = 1'b0;
      cycles++;
    end
    vec_count = 5'(cnt);
    chk({tag, ".cycles"}, 32'(cycles), 32'(2*eff));
    chk({tag, ".done"}, 32'(done), 1);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".pass"}, 32'(pass), 32'(exp_err == 0));
    chk({tag, ".err"}, 32'(err_count), 32'(exp_err));
    chk({tag, ".ffi"}, 32'(first_fail_idx), 32'(exp_ffi));
    if (eff > 0) begin
      last = model_mem[eff-1];
      chk({tag, ".last_ab"}, 32'({a, b, alu_control}), 32'(last[17:8]));
    end
  endtask

  initial begin
    reset = 1'b1; vec_we = 1'b0; vec_addr = '0; vec_wdata = '0; vec_count = '0; start = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Empty run: done and pass after one edge, operands untouched
    do_run("count0", 0, -1);
    chk("count0.a", 32'(a), 0);
    chk("count0.b", 32'(b), 0);
    chk("count0.ctrl", 32'(alu_control), 0);

    load_set(0);
    do_run("all_ok", 16, -1);
    load_set(1);
    do_run("bad_5_9", 16, -1);
    load_set(2);
    do_run("all_flags_bad", 16, -1);

    for (int r = 0; r < 4; r++) begin
      load_set(3);
      do_run($sformatf("rand%0d", r), $urandom_range(1, 16), -1);
    end
    do_run("count_clamp", 20, -1);

    // Mid-run start, write and vec_count change must not disturb the run or the memory
    load_set(0);
    do_run("inject", 16, 10);
    do_run("inject_rerun", 16, -1);

    // Asynchronous reset mid-run, then a clean run
    vec_count = 5'd16;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_reset.busy", 32'(busy), 1);
    #2 reset = 1'b1;
    #1 chk_all_zero("midrun_reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_run("after_reset", 16, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
